// File: rtl/tb_hwpe_stream_receiver_pkg.sv
// Shared types and constants for the HWPE stream receiver: LFSR taps,
// the status bundle and the LFSR step function.
package hwpe_stream_package;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] HWPE_STREAM_RECV_LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic [31:0] count;
    logic [31:0] beats;
    logic        full;
    logic        overflow;
    logic        protocol_err;
  } hwpe_stream_recv_status_t;

  function automatic logic [15:0] hwpe_stream_recv_lfsr_step(input logic [15:0] lfsr);
    return {lfsr[14:0], ^(lfsr & HWPE_STREAM_RECV_LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Minimal HWPE valid/ready stream interface with byte strobes.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;

  modport source (output valid, output data, output strb, input ready);
  modport sink   (input valid, input data, input strb, output ready);
endinterface

// File: rtl/tb_hwpe_stream_protocol_monitor.sv
// Stream protocol checker: once a beat is offered and not taken, valid,
// data and strb must hold until the handshake. Error flag is sticky.
module tb_hwpe_stream_protocol_monitor #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic                    valid_i,
  input  logic                    ready_i,
  input  logic [DATA_WIDTH-1:0]   data_i,
  input  logic [DATA_WIDTH/8-1:0] strb_i,
  output logic                    err_o
);

  logic                    pending_q, pending_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [DATA_WIDTH/8-1:0] strb_q, strb_d;
  logic                    err_q, err_d;
  logic                    violation;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    pending_d = pending_q;
    data_d    = data_q;
    strb_d    = strb_q;
    err_d     = err_q;
    violation = pending_q & (~valid_i | (data_i != data_q) | (strb_i != strb_q));
    if (clear_i) begin
      pending_d = 1'b0;
      err_d     = 1'b0;
    end else begin
      pending_d = valid_i & ~ready_i;
      if (valid_i & ~ready_i) begin
        data_d = data_i;
        strb_d = strb_i;
      end
      if (violation) err_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= 1'b0;
      data_q    <= '0;
      strb_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      data_q    <= data_d;
      strb_q    <= strb_d;
      err_q     <= err_d;
    end
  end

  assign err_o = err_q;

endmodule

// File: rtl/tb_hwpe_stream_receiver.sv
// Synthesizable HWPE stream sink: LFSR-driven backpressure, capture
// reservoir with registered readback, and a protocol monitor.
module tb_hwpe_stream_receiver
  import hwpe_stream_package::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned RESERVOIR_SIZE = 1024,
  parameter logic [7:0]  STALL_THRESH   = 8'd0,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  parameter bit          WRAP           = 1'b1
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              clear_i,
  input  logic                              enable_i,
  input  logic                              force_ready_i,
  input  logic                              force_stall_i,
  hwpe_stream_intf_stream.sink              data_i,
  input  logic [$clog2(RESERVOIR_SIZE)-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0]             rd_data_o,
  output logic [DATA_WIDTH/8-1:0]           rd_strb_o,
  output logic [$clog2(RESERVOIR_SIZE):0]   count_o,
  output logic [31:0]                       beats_o,
  output logic                              full_o,
  output logic                              overflow_o,
  output logic                              protocol_err_o
);

  localparam int unsigned AW = $clog2(RESERVOIR_SIZE);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = DATA_WIDTH / 8;

  logic [15:0]           lfsr_q, lfsr_d;
  logic                  ready_q, ready_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [31:0]           beats_q, beats_d;
  logic                  overflow_q, overflow_d;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [SW-1:0]         rd_strb_q;

  logic [DATA_WIDTH-1:0] mem_q      [RESERVOIR_SIZE];
  logic [SW-1:0]         strb_mem_q [RESERVOIR_SIZE];

  logic                     stall, ready_int, hs, mon_err;
  logic [DATA_WIDTH-1:0]    data_masked;
  hwpe_stream_recv_status_t status;

  always_comb begin
    status              = '0;
    status.count        = 32'(count_q);
    status.beats        = beats_q;
    status.full         = (status.count == 32'(RESERVOIR_SIZE));
    status.overflow     = overflow_q;
    status.protocol_err = mon_err;
  end

  // Ready is registered and independent of valid; clear and no-wrap full mask it combinationally.
  assign stall     = (lfsr_q[7:0] < STALL_THRESH);
  assign ready_int = ready_q & ~clear_i & ~(status.full & ~WRAP);
  assign hs        = data_i.valid & ready_int;
  assign data_i.ready = ready_int;

  always_comb begin
    data_masked = '0;
    for (int i = 0; i < int'(SW); i++) begin
      if (data_i.strb[i]) data_masked[8*i +: 8] = data_i.data[8*i +: 8];
    end
  end

  always_comb begin
    lfsr_d     = lfsr_q;
    ready_d    = enable_i & ~force_stall_i & (force_ready_i | ~stall);
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    beats_d    = beats_q;
    overflow_d = overflow_q;
    if (clear_i) begin
      lfsr_d     = LFSR_SEED;
      ready_d    = 1'b0;
      wr_ptr_d   = '0;
      count_d    = '0;
      beats_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (enable_i) lfsr_d = hwpe_stream_recv_lfsr_step(lfsr_q);
      if (hs) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        beats_d  = beats_q + 32'd1;
        if (status.full) overflow_d = 1'b1;
        else             count_d    = count_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q     <= LFSR_SEED;
      ready_q    <= 1'b0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      beats_q    <= '0;
      overflow_q <= 1'b0;
      rd_data_q  <= '0;
      rd_strb_q  <= '0;
    end else begin
      lfsr_q     <= lfsr_d;
      ready_q    <= ready_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      beats_q    <= beats_d;
      overflow_q <= overflow_d;
      rd_data_q  <= mem_q[rd_addr_i];
      rd_strb_q  <= strb_mem_q[rd_addr_i];
    end
  end

  // NOTE: the reservoir has no reset so it maps onto plain RAM; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (hs) begin
      mem_q[wr_ptr_q]      <= data_masked;
      strb_mem_q[wr_ptr_q] <= data_i.strb;
    end
  end

  tb_hwpe_stream_protocol_monitor #(
    .DATA_WIDTH (DATA_WIDTH)
  ) i_monitor (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .valid_i (data_i.valid),
    .ready_i (ready_int),
    .data_i  (data_i.data),
    .strb_i  (data_i.strb),
    .err_o   (mon_err)
  );

  assign rd_data_o      = rd_data_q;
  assign rd_strb_o      = rd_strb_q;
  assign count_o        = status.count[CW-1:0];
  assign beats_o        = status.beats;
  assign full_o         = status.full;
  assign overflow_o     = status.overflow;
  assign protocol_err_o = status.protocol_err;

endmodule

// File: tb/tb_tb_hwpe_stream_receiver.sv
// Directed bench for the stream receiver: one stalling DUT plus a pair of
// 4-entry DUTs (wrap / no-wrap) sharing one source.
module tb_tb_hwpe_stream_receiver;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Base DUT: 16 entries, 50% stall probability, wrapping.
  logic        b_clear, b_enable, b_force_ready, b_force_stall, b_valid;
  logic [31:0] b_data;
  logic [3:0]  b_strb, b_rd_addr, b_rd_strb;
  logic [31:0] b_rd_data, b_beats;
  logic [4:0]  b_count;
  logic        b_full, b_ovf, b_perr;

  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) intf_b ();
  assign intf_b.valid = b_valid;
  assign intf_b.data  = b_data;
  assign intf_b.strb  = b_strb;

  tb_hwpe_stream_receiver #(
    .DATA_WIDTH(32), .RESERVOIR_SIZE(16), .STALL_THRESH(8'd128),
    .LFSR_SEED(16'hACE1), .WRAP(1'b1)
  ) u_base (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(b_clear), .enable_i(b_enable),
    .force_ready_i(b_force_ready), .force_stall_i(b_force_stall), .data_i(intf_b),
    .rd_addr_i(b_rd_addr), .rd_data_o(b_rd_data), .rd_strb_o(b_rd_strb),
    .count_o(b_count), .beats_o(b_beats), .full_o(b_full),
    .overflow_o(b_ovf), .protocol_err_o(b_perr)
  );

  // Small pair: identical stimulus, WRAP=1 vs WRAP=0.
  logic        s_clear, s_enable, s_force_ready, s_force_stall, s_valid;
  logic [31:0] s_data;
  logic [3:0]  s_strb;
  logic [1:0]  s_rd_addr;
  logic [31:0] w_rd_data, w_beats, n_rd_data, n_beats;
  logic [3:0]  w_rd_strb, n_rd_strb;
  logic [2:0]  w_count, n_count;
  logic        w_full, w_ovf, w_perr, n_full, n_ovf, n_perr;

  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) intf_w ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) intf_n ();
  assign intf_w.valid = s_valid;
  assign intf_w.data  = s_data;
  assign intf_w.strb  = s_strb;
  assign intf_n.valid = s_valid;
  assign intf_n.data  = s_data;
  assign intf_n.strb  = s_strb;

  tb_hwpe_stream_receiver #(
    .DATA_WIDTH(32), .RESERVOIR_SIZE(4), .STALL_THRESH(8'd0),
    .LFSR_SEED(16'hACE1), .WRAP(1'b1)
  ) u_wrap (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(s_clear), .enable_i(s_enable),
    .force_ready_i(s_force_ready), .force_stall_i(s_force_stall), .data_i(intf_w),
    .rd_addr_i(s_rd_addr), .rd_data_o(w_rd_data), .rd_strb_o(w_rd_strb),
    .count_o(w_count), .beats_o(w_beats), .full_o(w_full),
    .overflow_o(w_ovf), .protocol_err_o(w_perr)
  );

  tb_hwpe_stream_receiver #(
    .DATA_WIDTH(32), .RESERVOIR_SIZE(4), .STALL_THRESH(8'd0),
    .LFSR_SEED(16'hACE1), .WRAP(1'b0)
  ) u_nowrap (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(s_clear), .enable_i(s_enable),
    .force_ready_i(s_force_ready), .force_stall_i(s_force_stall), .data_i(intf_n),
    .rd_addr_i(s_rd_addr), .rd_data_o(n_rd_data), .rd_strb_o(n_rd_strb),
    .count_o(n_count), .beats_o(n_beats), .full_o(n_full),
    .overflow_o(n_ovf), .protocol_err_o(n_perr)
  );

  localparam logic [31:0] EXP_WRAP [4] = '{32'hE, 32'hF, 32'hC, 32'hD};

  // Offer one beat on the base DUT, starting and ending at a falling edge.
  task automatic send_b(input logic [31:0] d, input logic [3:0] s);
    logic ok;
    ok      = 1'b0;
    b_valid = 1'b1;
    b_data  = d;
    b_strb  = s;
    for (int t = 0; t < 64 && !ok; t++) begin
      #1 ok = intf_b.ready;
      @(negedge clk);
    end
    b_valid = 1'b0;
    if (!ok) check("send_timeout", 32'(ok), 32'd1);
  endtask

  // Hold valid until the base DUT is caught stalling; returns at that falling edge.
  task automatic wait_stall_b();
    logic found;
    found = 1'b0;
    for (int t = 0; t < 200 && !found; t++) begin
      @(negedge clk);
      found = ~intf_b.ready;
    end
    if (!found) check("stall_timeout", 32'(found), 32'd1);
  endtask

  task automatic clear_b();
    @(negedge clk);
    b_clear = 1'b1;
    @(negedge clk);
    b_clear = 1'b0;
  endtask

  logic [31:0] pat_reset, pat_clear;
  int          rcnt;

  initial begin
    rst_n = 1'b0;
    {b_clear, b_force_stall, b_valid, b_force_ready} = '0;
    b_enable = 1'b1; b_data = '0; b_strb = 4'hF; b_rd_addr = '0;
    {s_clear, s_force_stall, s_valid} = '0;
    s_enable = 1'b1; s_force_ready = 1'b1; s_data = '0; s_strb = 4'hF; s_rd_addr = '0;

    repeat (3) @(negedge clk);
    check("rst_ready", 32'(intf_b.ready), 32'd0);
    check("rst_count", 32'(b_count), 32'd0);
    check("rst_beats", b_beats, 32'd0);
    check("rst_flags", {29'd0, b_full, b_ovf, b_perr}, 32'd0);
    check("rst_rd_data", b_rd_data, 32'd0);
    check("rst_rd_strb", 32'(b_rd_strb), 32'd0);

    // Ready pattern right after reset, random stall only.
    rst_n = 1'b1;
    for (int k = 0; k < 32; k++) begin
      @(posedge clk);
      @(negedge clk);
      pat_reset[k] = intf_b.ready;
    end

    // Duty cycle with a steady, well-behaved source.
    b_valid = 1'b1; b_data = 32'h55; b_strb = 4'hF;
    rcnt = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (intf_b.ready) rcnt++;
    end
    check("ready_duty_40_60", 32'(rcnt >= 400 && rcnt <= 600), 32'd1);
    check("perr_clean_source", 32'(b_perr), 32'd0);
    b_valid = 1'b0;
    b_clear = 1'b1;
    @(negedge clk);
    b_clear = 1'b0;

    // Violation: valid dropped while stalled.
    b_valid = 1'b1; b_data = 32'h11;
    wait_stall_b();
    @(posedge clk);
    #1 b_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("perr_valid_drop", 32'(b_perr), 32'd1);
    repeat (4) @(negedge clk);
    check("perr_sticky", 32'(b_perr), 32'd1);
    clear_b();
    check("perr_cleared", 32'(b_perr), 32'd0);

    // Violation: data 0x11 -> 0x22 while stalled.
    b_valid = 1'b1; b_data = 32'h11;
    wait_stall_b();
    @(posedge clk);
    #1 b_data = 32'h22;
    @(negedge clk);
    @(negedge clk);
    check("perr_data_change", 32'(b_perr), 32'd1);

    // Clear with valid high: ready masked in the clear cycle, state zeroed after.
    b_force_ready = 1'b1;
    @(negedge clk);
    b_clear = 1'b1;
    #1 check("clear_ready_low", 32'(intf_b.ready), 32'd0);
    @(negedge clk);
    b_clear = 1'b0;
    check("clear_count", 32'(b_count), 32'd0);
    check("clear_beats", b_beats, 32'd0);
    check("clear_perr", 32'(b_perr), 32'd0);
    @(negedge clk);
    @(negedge clk);
    b_valid = 1'b0;

    // Post-clear ready pattern must replay the post-reset one.
    b_force_ready = 1'b0;
    clear_b();
    for (int k = 0; k < 32; k++) begin
      @(posedge clk);
      @(negedge clk);
      pat_clear[k] = intf_b.ready;
    end
    check("clear_pattern", pat_clear, pat_reset);

    // Eight full-strobe beats, then readback.
    b_force_ready = 1'b1;
    for (int i = 1; i <= 8; i++) send_b(32'(i), 4'hF);
    check("main_count", 32'(b_count), 32'd8);
    check("main_beats", b_beats, 32'd8);
    check("main_perr", 32'(b_perr), 32'd0);
    for (int a = 0; a < 8; a++) begin
      b_rd_addr = 4'(a);
      @(negedge clk);
      check($sformatf("rd_data[%0d]", a), b_rd_data, 32'(a + 1));
      check($sformatf("rd_strb[%0d]", a), 32'(b_rd_strb), 32'hF);
    end

    // Partial strobe masks the unwritten bytes to zero.
    send_b(32'hDEADBEEF, 4'b0011);
    b_rd_addr = 4'd8;
    @(negedge clk);
    check("masked_data", b_rd_data, 32'h0000BEEF);
    check("masked_strb", 32'(b_rd_strb), 32'h3);

    // force_stall beats force_ready; enable low forces ready low.
    b_force_stall = 1'b1;
    @(negedge clk);
    check("force_stall_prio", 32'(intf_b.ready), 32'd0);
    b_force_stall = 1'b0;
    @(negedge clk);
    check("force_ready", 32'(intf_b.ready), 32'd1);
    b_enable = 1'b0;
    @(negedge clk);
    check("disable_ready", 32'(intf_b.ready), 32'd0);
    b_enable = 1'b1;

    // Six beats A..F into the 4-entry pair.
    for (int i = 0; i < 6; i++) begin
      s_valid = 1'b1;
      s_data  = 32'hA + 32'(i);
      @(negedge clk);
    end
    s_valid = 1'b0;
    @(negedge clk);
    check("wrap_count", 32'(w_count), 32'd4);
    check("wrap_full", 32'(w_full), 32'd1);
    check("wrap_overflow", 32'(w_ovf), 32'd1);
    check("wrap_beats", w_beats, 32'd6);
    check("nowrap_count", 32'(n_count), 32'd4);
    check("nowrap_beats", n_beats, 32'd4);
    check("nowrap_overflow", 32'(n_ovf), 32'd0);
    check("nowrap_ready", 32'(intf_n.ready), 32'd0);
    for (int a = 0; a < 4; a++) begin
      s_rd_addr = 2'(a);
      @(negedge clk);
      check($sformatf("wrap_rd[%0d]", a), w_rd_data, EXP_WRAP[a]);
      check($sformatf("nowrap_rd[%0d]", a), n_rd_data, 32'hA + 32'(a));
    end

    // Read of the entry being overwritten returns the old value first.
    s_rd_addr = 2'd2;
    s_data    = 32'h10;
    s_valid   = 1'b1;
    @(negedge clk);
    check("rd_during_wr_old", w_rd_data, 32'hC);
    s_valid = 1'b0;
    @(negedge clk);
    check("rd_during_wr_new", w_rd_data, 32'h10);

    // Asynchronous reset while a beat is being offered.
    b_force_ready = 1'b1;
    b_valid = 1'b1; b_data = 32'h77; b_strb = 4'hF;
    @(negedge clk);
    #1 check("pre_reset_ready", 32'(intf_b.ready), 32'd1);
    #1 rst_n = 1'b0;
    #1 check("async_rst_ready", 32'(intf_b.ready), 32'd0);
    check("async_rst_count", 32'(b_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("async_rst_beats", b_beats, 32'd0);
    b_valid = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached after %0d checks", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
